// File: rtl/paddle_arb_pkg.sv
// Shared definitions for the paddle source arbiter: owner codes, the
// quadrature Gray step table and the grant priority order.
package paddle_arb_pkg;

  // Owner codes double as the FSM state encoding, so o_owner is the state.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_JOY  = 2'd1,
    OWN_KEY  = 2'd2,
    OWN_ENC  = 2'd3
  } owner_e;

  // Grant priority for simultaneous movers, highest first in the MSBs:
  // enc > joy > key.
  localparam logic [5:0] PRIO_ORDER = {OWN_ENC, OWN_JOY, OWN_KEY};

  // +1 direction of the {B,A} sequence: 00 -> 01 -> 11 -> 10 -> 00.
  function automatic logic [1:0] next_up(input logic [1:0] q);
    logic [1:0] r;
    case (q)
      2'b00:   r = 2'b01;
      2'b01:   r = 2'b11;
      2'b11:   r = 2'b10;
      default: r = 2'b00;
    endcase
    return r;
  endfunction

  // -1 direction, the reverse walk of next_up.
  function automatic logic [1:0] next_dn(input logic [1:0] q);
    logic [1:0] r;
    case (q)
      2'b00:   r = 2'b10;
      2'b10:   r = 2'b11;
      2'b11:   r = 2'b01;
      default: r = 2'b00;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/quad_step_decoder.sv
// Decodes one quadrature sample pair into a +1 step, a -1 step, or an
// illegal two-bit jump. Purely combinational; prev==cur yields nothing.
module quad_step_decoder
  import paddle_arb_pkg::*;
(
  input  logic [1:0] prev,
  input  logic [1:0] cur,
  output logic       up,
  output logic       dn,
  output logic       err
);

  // A single-bit change is a step in exactly one direction; both bits is a jump.
  assign up  = (cur == next_up(prev));
  assign dn  = (cur == next_dn(prev));
  assign err = ((prev ^ cur) == 2'b11);

endmodule

// File: rtl/paddle_source_arbiter.sv
// Shares one paddle decoder between joystick steer, keyboard steer and a
// physical encoder. The first source to move owns the paddle until it has
// been idle for HOLD_TICKS cycles; its steps are accumulated and replayed
// as a rate-limited, single-bit-per-step quadrature stream on o_quad.
// o_owner is the registered FSM state and serves as the state debug view.
// There is no valid/ready handshake on this block: every input is a level
// sampled each clk16 cycle and every output is a registered level.
module paddle_source_arbiter
  import paddle_arb_pkg::*;
#(
  parameter int HOLD_TICKS = 16000,
  parameter int MIN_GAP    = 64,
  parameter int ACC_W      = 4
) (
  input  logic       clk16,
  input  logic       reset,
  input  logic       i_clr_owner,
  input  logic [1:0] i_q_joy,
  input  logic [1:0] i_q_key,
  input  logic [1:0] i_q_enc,
  output logic [1:0] o_quad,
  output logic [1:0] o_owner,
  output logic       o_err
);

  localparam int HOLD_W = $clog2(HOLD_TICKS + 1);
  localparam int GAP_W  = $clog2(MIN_GAP + 1);
  localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(HOLD_TICKS - 1);
  localparam logic [GAP_W-1:0]  GAP_RELOAD  = GAP_W'(MIN_GAP - 1);
  localparam logic signed [ACC_W:0] ACC_MAX = (ACC_W+1)'((2 ** (ACC_W - 1)) - 1);
  localparam logic signed [ACC_W:0] ACC_ONE = (ACC_W+1)'(1);

  logic [1:0]        enc_s1, enc_s2;
  logic [1:0]        prev_joy, prev_key, prev_enc;
  logic [1:0]        arm_cnt;
  logic              armed;
  logic              joy_up, joy_dn, joy_err;
  logic              key_up, key_dn, key_err;
  logic              enc_up, enc_dn, enc_err;
  logic [3:0]        up_v, dn_v, err_v, mov_v;
  owner_e            state, sel;
  logic              own_up, own_dn, own_err, own_step;
  logic [HOLD_W-1:0] hold_cnt;
  logic [GAP_W-1:0]  gap_cnt;
  logic [ACC_W-1:0]  acc, acc_next;
  logic              acc_pos, drain;
  logic signed [ACC_W:0] acc_sum;

  // Encoder synchronizer, per-source history and the post-reset arm window.
  always_ff @(posedge clk16) begin
    if (reset) begin
      enc_s1   <= 2'b00;
      enc_s2   <= 2'b00;
      prev_joy <= 2'b00;
      prev_key <= 2'b00;
      prev_enc <= 2'b00;
      arm_cnt  <= 2'd3;
    end else begin
      enc_s1   <= i_q_enc;
      enc_s2   <= enc_s1;
      prev_joy <= i_q_joy;
      prev_key <= i_q_key;
      prev_enc <= enc_s2;
      if (arm_cnt != 2'd0) arm_cnt <= arm_cnt - 2'd1;
    end
  end

  assign armed = (arm_cnt == 2'd0);

  quad_step_decoder u_dec_joy (.prev(prev_joy), .cur(i_q_joy), .up(joy_up), .dn(joy_dn), .err(joy_err));
  quad_step_decoder u_dec_key (.prev(prev_key), .cur(i_q_key), .up(key_up), .dn(key_dn), .err(key_err));
  quad_step_decoder u_dec_enc (.prev(prev_enc), .cur(enc_s2),  .up(enc_up), .dn(enc_dn), .err(enc_err));

  // Event vectors indexed by owner code; slot 0 (no owner) is always quiet.
  assign up_v  = {armed & enc_up,  armed & key_up,  armed & joy_up,  1'b0};
  assign dn_v  = {armed & enc_dn,  armed & key_dn,  armed & joy_dn,  1'b0};
  assign err_v = {armed & enc_err, armed & key_err, armed & joy_err, 1'b0};
  assign mov_v = up_v | dn_v | err_v;

  // Pick whose events count this cycle: the current owner, or the highest
  // priority mover when idle (so the granting step is applied immediately).
  always_comb begin
    sel = OWN_NONE;
    if (state == OWN_NONE) begin
      for (int i = 2; i >= 0; i--) begin
        if (sel == OWN_NONE && mov_v[PRIO_ORDER[2*i +: 2]]) begin
          sel = owner_e'(PRIO_ORDER[2*i +: 2]);
        end
      end
    end else begin
      sel = state;
    end
  end

  assign own_up   = up_v[sel];
  assign own_dn   = dn_v[sel];
  assign own_err  = err_v[sel];
  assign own_step = own_up | own_dn | own_err;

  // Ownership FSM with its hold timer; an explicit clear always wins.
  always_ff @(posedge clk16) begin
    if (reset) begin
      state    <= OWN_NONE;
      hold_cnt <= '0;
    end else if (i_clr_owner) begin
      state    <= OWN_NONE;
      hold_cnt <= '0;
    end else begin
      case (state)
        OWN_NONE: begin
          if (sel != OWN_NONE) begin
            state    <= sel;
            hold_cnt <= HOLD_RELOAD;
          end
        end
        default: begin
          if (own_step) begin
            hold_cnt <= HOLD_RELOAD;
          end else if (hold_cnt == '0) begin
            state <= OWN_NONE;
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
          end
        end
      endcase
    end
  end

  assign o_owner = state;

  // One output step is released whenever the gap has elapsed and work is pending.
  assign acc_pos = ~acc[ACC_W-1] && (acc != '0);
  assign drain   = (gap_cnt == '0) && (acc != '0);

  // Next accumulator: owner step plus drain, saturated symmetrically.
  always_comb begin
    acc_sum = {acc[ACC_W-1], acc};
    if (own_up) acc_sum = acc_sum + ACC_ONE;
    if (own_dn) acc_sum = acc_sum - ACC_ONE;
    if (drain)  acc_sum = acc_pos ? (acc_sum - ACC_ONE) : (acc_sum + ACC_ONE);
    if (acc_sum > ACC_MAX)  acc_sum = ACC_MAX;
    if (acc_sum < -ACC_MAX) acc_sum = -ACC_MAX;
    acc_next = acc_sum[ACC_W-1:0];
  end

  // Accumulator, gap counter and the Gray output stepper.
  always_ff @(posedge clk16) begin
    if (reset) begin
      acc     <= '0;
      gap_cnt <= '0;
      o_quad  <= 2'b00;
      o_err   <= 1'b0;
    end else begin
      o_err <= own_err & ~i_clr_owner;
      if (i_clr_owner) begin
        // Pending work is discarded; o_quad stays where it is.
        acc <= '0;
        if (gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;
      end else begin
        acc <= acc_next;
        if (drain) begin
          o_quad  <= acc_pos ? next_up(o_quad) : next_dn(o_quad);
          gap_cnt <= GAP_RELOAD;
        end else if (gap_cnt != '0) begin
          gap_cnt <= gap_cnt - 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_paddle_source_arbiter.sv
// Directed bench for paddle_source_arbiter with hand-computed expectations.
module tb_paddle_source_arbiter;
  import paddle_arb_pkg::*;

  localparam int HOLD_TICKS = 16000;
  localparam int MIN_GAP    = 64;

  logic       clk16 = 1'b0;
  logic       reset = 1'b1;
  logic       i_clr_owner = 1'b0;
  logic [1:0] i_q_joy = 2'b00;
  logic [1:0] i_q_key = 2'b00;
  logic [1:0] i_q_enc = 2'b00;
  logic [1:0] o_quad;
  logic [1:0] o_owner;
  logic       o_err;

  int checks = 0;
  int errors = 0;
  logic [1:0] exp_q[$];

  // Clock and watchdog
  always #5 clk16 = ~clk16;

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  paddle_source_arbiter #(.HOLD_TICKS(HOLD_TICKS), .MIN_GAP(MIN_GAP), .ACC_W(4)) dut (
    .clk16       (clk16),
    .reset       (reset),
    .i_clr_owner (i_clr_owner),
    .i_q_joy     (i_q_joy),
    .i_q_key     (i_q_key),
    .i_q_enc     (i_q_enc),
    .o_quad      (o_quad),
    .o_owner     (o_owner),
    .o_err       (o_err)
  );

  // Driver tasks
  task automatic tick();
    @(posedge clk16);
    #1;
  endtask

  task automatic pulse_clr();
    i_clr_owner = 1'b1;
    tick();
    i_clr_owner = 1'b0;
  endtask

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic wait_quad_change(output int n);
    logic [1:0] q0;
    q0 = o_quad;
    n = 0;
    do begin
      tick();
      n++;
    end while (o_quad == q0 && n < 300);
  endtask

  int n;
  int emitted;
  logic [1:0] last_q;

  initial begin
    // Reset values
    repeat (3) tick();
    check("rst_quad",  int'(o_quad),  0);
    check("rst_owner", int'(o_owner), 0);
    check("rst_err",   int'(o_err),   0);
    reset = 1'b0;
    repeat (5) tick();

    // 1: joy 00->01->11, second step spaced by MIN_GAP
    i_q_joy = 2'b01;
    tick();
    check("t1_owner", int'(o_owner), 1);
    check("t1_quad0", int'(o_quad), 0);
    tick();
    check("t1_quad1", int'(o_quad), 1);
    check("t1_err",   int'(o_err), 0);
    i_q_joy = 2'b11;
    wait_quad_change(n);
    check("t1_gap",   n, MIN_GAP);
    check("t1_quad2", int'(o_quad), 3);

    // 2: enc ignored while joy owns; hold expiry; enc then takes over
    i_q_joy = 2'b10;
    n = 0;
    while (o_owner != 2'd0 && n < HOLD_TICKS + 100) begin
      tick();
      n++;
      if (n == 1)   i_q_enc = 2'b01;
      if (n == 4)   check("t2_owner_kept", int'(o_owner), 1);
      if (n == 100) check("t2_quad", int'(o_quad), 2);
    end
    check("t2_hold", n, HOLD_TICKS + 1);
    i_q_enc = 2'b11;
    repeat (3) tick();
    check("t2_enc_owner", int'(o_owner), 3);
    tick();
    check("t2_enc_quad", int'(o_quad), 0);

    // 3: simultaneous enc and joy from idle -> enc wins, one step only
    pulse_clr();
    check("t3_clr_owner", int'(o_owner), 0);
    repeat (70) tick();
    i_q_enc = 2'b10;
    tick();
    tick();
    i_q_joy = 2'b00;
    tick();
    check("t3_owner", int'(o_owner), 3);
    tick();
    check("t3_quad", int'(o_quad), 1);
    repeat (80) tick();
    check("t3_quad_single", int'(o_quad), 1);

    // 4: enc owner two-bit jump -> one-cycle err, no output step
    i_q_enc = 2'b01;
    tick();
    tick();
    check("t4_err_early", int'(o_err), 0);
    tick();
    check("t4_err_pulse", int'(o_err), 1);
    check("t4_owner", int'(o_owner), 3);
    tick();
    check("t4_err_clear", int'(o_err), 0);
    repeat (80) tick();
    check("t4_quad", int'(o_quad), 1);

    // 5: burst of 10 +1 steps saturates at 7 -> seven spaced output steps
    pulse_clr();
    check("t5_clr_owner", int'(o_owner), 0);
    i_q_joy = 2'b01;
    tick();
    check("t5_owner", int'(o_owner), 1);
    tick();
    check("t5_quad_first", int'(o_quad), 3);
    exp_q = '{2'b10, 2'b00, 2'b01, 2'b11, 2'b10, 2'b00, 2'b01};
    last_q = o_quad;
    emitted = 0;
    for (int t = 0; t < 600; t++) begin
      if (t < 10) i_q_joy = next_up(i_q_joy);
      tick();
      if (o_quad != last_q) begin
        emitted++;
        check("t5_time", t + 1, MIN_GAP * emitted);
        if (exp_q.size() > 0) check("t5_quad", int'(o_quad), int'(exp_q.pop_front()));
        else check("t5_extra", emitted, 7);
        last_q = o_quad;
      end
    end
    check("t5_count", emitted, 7);
    check("t5_left", exp_q.size(), 0);

    // 6: clear mid-drain with acc=3 freezes o_quad
    for (int k = 0; k < 4; k++) begin
      i_q_joy = next_up(i_q_joy);
      tick();
    end
    check("t6_quad_pre", int'(o_quad), 3);
    pulse_clr();
    check("t6_owner", int'(o_owner), 0);
    check("t6_quad_clr", int'(o_quad), 3);
    repeat (200) tick();
    check("t6_quad_frozen", int'(o_quad), 3);
    check("t6_owner_idle", int'(o_owner), 0);

    // Reset mid-operation
    i_q_joy = next_up(i_q_joy);
    tick();
    i_q_joy = next_up(i_q_joy);
    tick();
    check("rst2_pre_owner", int'(o_owner), 1);
    check("rst2_pre_quad", int'(o_quad), 2);
    reset = 1'b1;
    tick();
    check("rst2_quad",  int'(o_quad),  0);
    check("rst2_owner", int'(o_owner), 0);
    check("rst2_err",   int'(o_err),   0);

    // Arm window absorbs an input change at reset release
    reset = 1'b0;
    i_q_joy = 2'b11;
    repeat (5) tick();
    check("arm_absorb", int'(o_owner), 0);
    i_q_joy = 2'b10;
    tick();
    check("arm_owner", int'(o_owner), 1);
    tick();
    check("arm_quad", int'(o_quad), 1);

    // Final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
